// File: rtl/vga_fb_fetch_ctrl.sv
// Framebuffer fetch sequencer: walks the active bank once per frame and
// issues FIFO-throttled, 4 KB-clipped read bursts to the AXI read master.
module vga_fb_fetch_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_AW    = 9
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  vbse_i,
   input  logic [1:0]            mode_i,
   input  logic [7:0]            brulen_i,
   input  logic [15:0]           hvlen_i,
   input  logic [15:0]           vvlen_i,
   input  logic [ADDR_WIDTH-1:0] fbba1_i,
   input  logic [ADDR_WIDTH-1:0] fbba2_i,
   input  logic                  frame_start_i,
   input  logic [FIFO_AW:0]      fifo_free_i,
   output logic                  req_valid_o,
   input  logic                  req_ready_i,
   output logic [ADDR_WIDTH-1:0] req_addr_o,
   output logic [7:0]            req_len_o,
   input  logic                  rsp_last_i,
   output logic                  cfb_o,
   output logic                  vbsif_set_o,
   output logic                  ovr_o,
   output logic                  busy_o
);

   typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, DONE} state_t;

   state_t                  state_reg, state_next;
   logic                    cfb_reg, cfb_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic [31:0]             remaining_reg, remaining_next;
   logic                    valid_reg, valid_next;
   logic [7:0]              len_reg, len_next;
   logic                    pend_reg, pend_next;

   logic [31:0]             pixels;
   logic [32:0]             bytes33;
   logic [33:0]             bytes_rnd;
   logic [31:0]             total_beats;
   logic [12:0]             page_bytes;
   logic [10:0]             page_beats;
   logic [10:0]             beats;
   logic                    fifo_ok;
   logic                    handshake;
   logic [8:0]              burst_beats;
   logic                    new_cfb;
   logic [ADDR_WIDTH-1:0]   base_raw;

   // RGB332 (mode 0) is one byte per pixel, all other formats are two
   assign pixels      = 32'(hvlen_i) * 32'(vvlen_i);
   assign bytes33     = (mode_i != 2'b00) ? {pixels, 1'b0} : {1'b0, pixels};
   assign bytes_rnd   = {1'b0, bytes33} + 34'd3;
   assign total_beats = bytes_rnd[33:2];

   assign page_bytes  = 13'd4096 - {1'b0, addr_reg[11:0]};
   assign page_beats  = page_bytes[12:2];

   always_comb begin
      beats = {3'b000, brulen_i} + 11'd1;
      if (page_beats < beats)
         beats = page_beats;
      if (remaining_reg < 32'(beats))
         beats = remaining_reg[10:0];
   end

   assign fifo_ok     = 32'(fifo_free_i) >= 32'(beats);
   assign handshake   = valid_reg && req_ready_i;
   assign burst_beats = {1'b0, len_reg} + 9'd1;
   assign new_cfb     = cfb_reg ^ vbse_i;
   assign base_raw    = new_cfb ? fbba2_i : fbba1_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         cfb_reg       <= 1'b0;
         addr_reg      <= '0;
         remaining_reg <= '0;
         valid_reg     <= 1'b0;
         len_reg       <= '0;
         pend_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cfb_reg       <= cfb_next;
         addr_reg      <= addr_next;
         remaining_reg <= remaining_next;
         valid_reg     <= valid_next;
         len_reg       <= len_next;
         pend_reg      <= pend_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cfb_next       = cfb_reg;
      addr_next      = addr_reg;
      remaining_next = remaining_reg;
      valid_next     = valid_reg;
      len_next       = len_reg;
      pend_next      = pend_reg;
      case (state_reg)
         IDLE: begin
            if (en_i && frame_start_i)
               state_next = LOAD;
         end
         LOAD: begin
            cfb_next       = new_cfb;
            addr_next      = {base_raw[ADDR_WIDTH-1:2], 2'b00};
            remaining_next = total_beats;
            pend_next      = 1'b0;
            valid_next     = 1'b0;
            state_next     = (total_beats == 32'd0) ? DONE : REQ;
         end
         REQ: begin
            if (handshake) begin
               addr_next      = addr_reg + ADDR_WIDTH'({burst_beats, 2'b00});
               remaining_next = remaining_reg - 32'(burst_beats);
               valid_next     = 1'b0;
               pend_next      = frame_start_i;
               state_next     = WAIT;
            end else if (!en_i) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end else if (frame_start_i) begin
               valid_next = 1'b0;
               state_next = LOAD;
            end else if (!valid_reg && fifo_ok) begin
               // latched here so the request stays stable until accepted
               valid_next = 1'b1;
               len_next   = 8'(beats - 11'd1);
            end
         end
         WAIT: begin
            if (rsp_last_i) begin
               pend_next = 1'b0;
               if (!en_i)
                  state_next = IDLE;
               else if (pend_reg || frame_start_i)
                  state_next = LOAD;
               else if (remaining_reg != 32'd0)
                  state_next = REQ;
               else
                  state_next = DONE;
            end else if (frame_start_i) begin
               pend_next = 1'b1;
            end
         end
         DONE: begin
            if (!en_i)
               state_next = IDLE;
            else if (frame_start_i)
               state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_reg == LOAD) || (state_reg == REQ) || (state_reg == WAIT);
      vbsif_set_o = (state_reg == LOAD) && vbse_i;
      ovr_o       = 1'b0;
      if (state_reg == REQ)
         ovr_o = frame_start_i && (handshake || en_i);
      else if (state_reg == WAIT)
         ovr_o = frame_start_i && !pend_reg &&
                 !(rsp_last_i && remaining_reg == 32'd0);
   end

   assign req_valid_o = valid_reg;
   assign req_addr_o  = addr_reg;
   assign req_len_o   = len_reg;
   assign cfb_o       = cfb_reg;

endmodule

// File: tb/tb_vga_fb_fetch_ctrl.sv
// Directed bench for vga_fb_fetch_ctrl: single frame, full VGA frame,
// 4 KB clipping, FIFO throttling, bank switching, overrun and reset.
module tb_vga_fb_fetch_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        en_i;
   logic        vbse_i;
   logic [1:0]  mode_i;
   logic [7:0]  brulen_i;
   logic [15:0] hvlen_i;
   logic [15:0] vvlen_i;
   logic [31:0] fbba1_i;
   logic [31:0] fbba2_i;
   logic        frame_start_i;
   logic [9:0]  fifo_free_i;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [31:0] req_addr_o;
   logic [7:0]  req_len_o;
   logic        rsp_last_i;
   logic        cfb_o;
   logic        vbsif_set_o;
   logic        ovr_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   int ovr_cnt = 0;

   vga_fb_fetch_ctrl #(.ADDR_WIDTH(32), .FIFO_AW(9)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .vbse_i(vbse_i),
      .mode_i(mode_i), .brulen_i(brulen_i), .hvlen_i(hvlen_i),
      .vvlen_i(vvlen_i), .fbba1_i(fbba1_i), .fbba2_i(fbba2_i),
      .frame_start_i(frame_start_i), .fifo_free_i(fifo_free_i),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
      .req_addr_o(req_addr_o), .req_len_o(req_len_o),
      .rsp_last_i(rsp_last_i), .cfb_o(cfb_o), .vbsif_set_o(vbsif_set_o),
      .ovr_o(ovr_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i)
      if (ovr_o === 1'b1) ovr_cnt++;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_frame();
      frame_start_i = 1'b1;
      step();
      frame_start_i = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (req_valid_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic serve(output logic [31:0] a, output logic [7:0] l, output bit ok);
      wait_valid(ok);
      a = req_addr_o;
      l = req_len_o;
      if (ok) begin
         req_ready_i = 1'b1;
         step();
         req_ready_i = 1'b0;
         rsp_last_i = 1'b1;
         step();
         rsp_last_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      step();
      step();
      checks++;
      if ({req_valid_o, busy_o, cfb_o, vbsif_set_o, ovr_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, need 00000",
                  {req_valid_o, busy_o, cfb_o, vbsif_set_o, ovr_o});
      end
      checks++;
      if (req_addr_o !== 32'h0 || req_len_o !== 8'h0) begin
         errors++;
         $display("FAIL reset_addr_len: got %h/%h, need 0/0", req_addr_o, req_len_o);
      end
      rst_i = 1'b0;
      step();
      $display("test_reset done");
   endtask

   task automatic test_single();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      en_i = 1'b1; mode_i = 2'b00; brulen_i = 8'd15;
      hvlen_i = 16'd8; vvlen_i = 16'd2; fbba1_i = 32'h8000_0000;
      fifo_free_i = 10'd512;
      step();
      pulse_frame();
      checks++;
      if (busy_o !== 1'b1 || req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL load_cycle: busy=%b valid=%b, need busy=1 valid=0", busy_o, req_valid_o);
      end
      serve(a, l, ok);
      checks++;
      if (!ok || a !== 32'h8000_0000 || l !== 8'd3) begin
         errors++;
         $display("FAIL single_req: ok=%0d addr=%h len=%0d, need addr=80000000 len=3", ok, a, l);
      end
      checks++;
      if (busy_o !== 1'b0 || req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL single_done: busy=%b valid=%b, need 0 0", busy_o, req_valid_o);
      end
      $display("test_single: addr=%h len=%0d", a, l);
   endtask

   task automatic test_4k_clip();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      mode_i = 2'b11; hvlen_i = 16'd16; vvlen_i = 16'd1; fbba1_i = 32'h0000_0FF0;
      step();
      pulse_frame();
      serve(a, l, ok);
      checks++;
      if (!ok || a !== 32'h0000_0FF0 || l !== 8'd3) begin
         errors++;
         $display("FAIL clip_first: addr=%h len=%0d, need 00000ff0 len=3", a, l);
      end
      serve(a, l, ok);
      checks++;
      if (!ok || a !== 32'h0000_1000 || l !== 8'd3) begin
         errors++;
         $display("FAIL clip_second: addr=%h len=%0d, need 00001000 len=3", a, l);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL clip_done: busy=%b, need 0", busy_o);
      end
      $display("test_4k_clip: second addr=%h len=%0d", a, l);
   endtask

   task automatic test_throttle();
      bit          low_ok = 1'b1;
      bit          stable = 1'b1;
      mode_i = 2'b00; hvlen_i = 16'd8; vvlen_i = 16'd2; fbba1_i = 32'h8000_0000;
      brulen_i = 8'd3; fifo_free_i = 10'd3;
      step();
      pulse_frame();
      for (int i = 0; i < 6; i++) begin
         if (req_valid_o !== 1'b0) low_ok = 1'b0;
         step();
      end
      checks++;
      if (!low_ok) begin
         errors++;
         $display("FAIL throttle_low: valid rose with fifo_free=3, need low");
      end
      fifo_free_i = 10'd4;
      step();
      checks++;
      if (req_valid_o !== 1'b1 || req_len_o !== 8'd3 || req_addr_o !== 32'h8000_0000) begin
         errors++;
         $display("FAIL throttle_rise: valid=%b len=%0d addr=%h, need 1 3 80000000",
                  req_valid_o, req_len_o, req_addr_o);
      end
      brulen_i = 8'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (req_valid_o !== 1'b1 || req_len_o !== 8'd3 || req_addr_o !== 32'h8000_0000)
            stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL hold_stable: valid=%b len=%0d addr=%h, need 1 3 80000000",
                  req_valid_o, req_len_o, req_addr_o);
      end
      req_ready_i = 1'b1;
      step();
      req_ready_i = 1'b0;
      rsp_last_i = 1'b1;
      step();
      rsp_last_i = 1'b0;
      fifo_free_i = 10'd512;
      brulen_i = 8'd15;
      $display("test_throttle: stable=%0d", stable);
   endtask

   task automatic test_overrun();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      brulen_i = 8'd3; mode_i = 2'b00; hvlen_i = 16'd208; vvlen_i = 16'd2;
      fbba1_i = 32'h8000_0000;
      step();
      pulse_frame();
      wait_valid(ok);
      req_ready_i = 1'b1;
      step();
      req_ready_i = 1'b0;
      frame_start_i = 1'b1;
      #1;
      checks++;
      if (ovr_o !== 1'b1) begin
         errors++;
         $display("FAIL ovr_pulse: got %b, need 1", ovr_o);
      end
      step();
      frame_start_i = 1'b0;
      step();
      frame_start_i = 1'b1;
      #1;
      checks++;
      if (ovr_o !== 1'b0) begin
         errors++;
         $display("FAIL ovr_collapse: got %b, need 0", ovr_o);
      end
      step();
      frame_start_i = 1'b0;
      rsp_last_i = 1'b1;
      step();
      rsp_last_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1 || req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL ovr_reload: busy=%b valid=%b, need 1 0", busy_o, req_valid_o);
      end
      wait_valid(ok);
      checks++;
      if (!ok || req_addr_o !== 32'h8000_0000 || req_len_o !== 8'd3) begin
         errors++;
         $display("FAIL ovr_restart: addr=%h len=%0d, need 80000000 len=3", req_addr_o, req_len_o);
      end
      req_ready_i = 1'b1;
      step();
      req_ready_i = 1'b0;
      rst_i = 1'b1;
      #1;
      checks++;
      if ({req_valid_o, busy_o, cfb_o, vbsif_set_o, ovr_o} !== 5'b0 || req_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_wait: flags=%b addr=%h, need 00000 0",
                  {req_valid_o, busy_o, cfb_o, vbsif_set_o, ovr_o}, req_addr_o);
      end
      step();
      rst_i = 1'b0;
      step();
      brulen_i = 8'd15;
      $display("test_overrun done");
   endtask

   task automatic test_full_frame();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok = 1'b1;
      int          n = 0;
      int          bad = 0;
      int          ovr_base;
      logic [31:0] last_a = 32'h0;
      mode_i = 2'b11; hvlen_i = 16'd640; vvlen_i = 16'd480; brulen_i = 8'd15;
      fbba1_i = 32'h8000_0000;
      step();
      ovr_base = ovr_cnt;
      pulse_frame();
      while (n < 9600 && ok) begin
         serve(a, l, ok);
         if (ok) begin
            if (a !== 32'h8000_0000 + 32'(n) * 32'd64 || l !== 8'd15) bad++;
            last_a = a;
            n++;
         end
      end
      checks++;
      if (n !== 9600 || bad !== 0) begin
         errors++;
         $display("FAIL full_count: got %0d requests, %0d wrong; need 9600, 0", n, bad);
      end
      checks++;
      if (last_a !== 32'h8009_5FC0) begin
         errors++;
         $display("FAIL full_last_addr: got %h, need 80095fc0", last_a);
      end
      checks++;
      if (ovr_cnt - ovr_base !== 0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL full_end: ovr pulses=%0d busy=%b, need 0 0", ovr_cnt - ovr_base, busy_o);
      end
      $display("test_full_frame: %0d requests, last addr=%h", n, last_a);
   endtask

   task automatic test_bank_switch();
      logic [31:0] a;
      logic [7:0]  l;
      bit          ok;
      logic [31:0] exp_base;
      logic        exp_cfb;
      vbse_i = 1'b1; fbba1_i = 32'h8000_0000; fbba2_i = 32'h9000_0000;
      mode_i = 2'b00; hvlen_i = 16'd8; vvlen_i = 16'd2;
      step();
      for (int k = 0; k < 3; k++) begin
         exp_cfb  = (k % 2 == 0);
         exp_base = exp_cfb ? 32'h9000_0000 : 32'h8000_0000;
         pulse_frame();
         checks++;
         if (vbsif_set_o !== 1'b1) begin
            errors++;
            $display("FAIL vbsif_%0d: got %b, need 1", k, vbsif_set_o);
         end
         serve(a, l, ok);
         checks++;
         if (!ok || a !== exp_base || cfb_o !== exp_cfb || vbsif_set_o !== 1'b0) begin
            errors++;
            $display("FAIL bank_%0d: addr=%h cfb=%b vbsif=%b, need %h %b 0",
                     k, a, cfb_o, vbsif_set_o, exp_base, exp_cfb);
         end
         $display("test_bank_switch frame %0d: addr=%h cfb=%b", k, a, cfb_o);
         step();
         step();
      end
      vbse_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; en_i = 1'b0; vbse_i = 1'b0; mode_i = 2'b00; brulen_i = 8'd15;
      hvlen_i = 16'd0; vvlen_i = 16'd0; fbba1_i = 32'h0; fbba2_i = 32'h0;
      frame_start_i = 1'b0; fifo_free_i = 10'd512; req_ready_i = 1'b0; rsp_last_i = 1'b0;
      test_reset();
      test_single();
      test_4k_clip();
      test_throttle();
      test_overrun();
      en_i = 1'b1;
      test_full_frame();
      test_bank_switch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
